// File: rtl/pb_arbiter_pkg.sv
// Shared definitions for the native-bus round-robin arbiter.
// State encoding and the default read value for timed-out accesses.
package pb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } pb_state_e;

  localparam logic [31:0] PB_TO_RDATA = 32'hffffffff;

endpackage

// File: rtl/pb_arbiter_rr_pick.sv
// Combinational round-robin selector: first request after last_i,
// scanning last_i+1, last_i+2, ... modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic [GW-1:0] win_o,
  output logic          any_o
);

  int unsigned j;

  // Scan far-to-near so the nearest requester is assigned last.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j]) begin
        win_o = GW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_arbiter.sv
// Round-robin arbiter sharing one native bus between N masters,
// with a forced idle cycle between accesses and optional watchdog.
module pb_arbiter
  import pb_arbiter_pkg::*;
#(
  parameter int          N        = 2,
  parameter int          TIMEOUT  = 0,
  parameter int          TW       = 8,
  parameter logic [31:0] TO_RDATA = PB_TO_RDATA,
  localparam int         GW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [32*N-1:0] m_addr,
  input  logic [32*N-1:0] m_wdata,
  input  logic [4*N-1:0]  m_wstrb,
  input  logic [N-1:0]    m_valid,
  output logic [N-1:0]    m_ready,
  output logic [31:0]     m_rdata,
  output logic [31:0]     s_addr,
  output logic [31:0]     s_wdata,
  output logic [3:0]      s_wstrb,
  output logic            s_valid,
  input  logic            s_ready,
  input  logic [31:0]     s_rdata,
  output logic [GW-1:0]   grant,
  output logic            to_err
);

  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  pb_state_e     state_q;
  logic [GW-1:0] grant_q;
  logic [TW-1:0] cnt_q;

  logic [GW-1:0] win;
  logic          any;
  logic          g_valid;
  logic          expire;
  logic          done;

  rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req_i  (m_valid),
    .last_i (grant_q),
    .win_o  (win),
    .any_o  (any)
  );

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    g_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == GW'(i)) begin
        s_addr  = m_addr[32*i +: 32];
        s_wdata = m_wdata[32*i +: 32];
        s_wstrb = m_wstrb[4*i +: 4];
        g_valid = m_valid[i];
      end
    end
  end

  assign s_valid = (state_q == ST_BUSY) && g_valid;

  // s_ready beats a coinciding expiry, so expiry requires !s_ready.
  assign expire = (TIMEOUT > 0) && s_valid && !s_ready
                  && (cnt_q == TO_LAST);
  assign done   = s_valid && (s_ready || expire);

  always_comb begin
    m_ready = '0;
    for (int i = 0; i < N; i++) begin
      m_ready[i] = done && (grant_q == GW'(i));
    end
  end

  assign m_rdata = expire ? TO_RDATA : s_rdata;
  assign to_err  = expire;
  assign grant   = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GW'(N - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any) begin
            grant_q <= win;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_valid) begin
            state_q <= ST_IDLE;
          end else if (done) begin
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_arbiter.sv
// Directed bench for pb_arbiter: two masters, 16-cycle watchdog.
// Inputs change 2ns after posedge; outputs sampled 1ns later.
module tb_pb_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   m_addr;
  logic [63:0]   m_wdata;
  logic [7:0]    m_wstrb;
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_ready;
  logic [31:0]   m_rdata;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_rdata;
  logic [0:0]    grant;
  logic          to_err;

  logic          auto_ack;
  logic          s_ready_man;

  int tests = 0;
  int fails = 0;

  assign s_ready = auto_ack ? s_valid : s_ready_man;

  always #5 clk = ~clk;

  pb_arbiter #(
    .N       (N),
    .TIMEOUT (16),
    .TW      (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .grant   (grant),
    .to_err  (to_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_addr = '0;
    m_wdata = '0;
    m_wstrb = '0;
    m_valid = '0;
    s_rdata = '0;
    s_ready_man = 1'b0;
    auto_ack = 1'b0;
    tick();
    tick();
    #1;
    tests++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_s_valid got %b want 0", s_valid);
    end
    tests++;
    if (m_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_m_ready got %b want 00", m_ready);
    end
    tests++;
    if (to_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_to_err got %b want 0", to_err);
    end
    tests++;
    if (grant !== 1'b1) begin
      fails++;
      $display("FAIL reset_grant got %0d want 1", grant);
    end
  endtask

  task automatic test_single_read();
    rst = 1'b0;
    m_addr[31:0] = 32'h0000_0010;
    m_valid = 2'b01;
    #1;
    tests++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL rd_c0_s_valid got %b want 0", s_valid);
    end
    tick();
    #1;
    tests++;
    if (s_valid !== 1'b1 || s_addr !== 32'h10 || s_wstrb !== 4'h0) begin
      fails++;
      $display("FAIL rd_c1_req got v=%b a=%h s=%h want v=1 a=00000010 s=0",
               s_valid, s_addr, s_wstrb);
    end
    tests++;
    if (grant !== 1'b0 || m_ready !== 2'b00) begin
      fails++;
      $display("FAIL rd_c1_grant got g=%0d r=%b want g=0 r=00",
               grant, m_ready);
    end
    tick();
    s_ready_man = 1'b1;
    s_rdata = 32'h1234_5678;
    #1;
    tests++;
    if (m_ready !== 2'b01 || m_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL rd_c2_ack got r=%b d=%h want r=01 d=12345678",
               m_ready, m_rdata);
    end
    tick();
    s_ready_man = 1'b0;
    m_valid = 2'b00;
    #1;
    tests++;
    if (s_valid !== 1'b0 || m_ready !== 2'b00) begin
      fails++;
      $display("FAIL rd_c3_gap got v=%b r=%b want v=0 r=00",
               s_valid, m_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int cyc;
    int last;
    int n;
    rst = 1'b1;
    m_valid = 2'b00;
    tick();
    rst = 1'b0;
    m_valid = 2'b11;
    auto_ack = 1'b1;
    s_rdata = 32'ha5a5_0001;
    cyc = 0;
    last = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        #1;
        cyc++;
        n++;
      end while (m_ready === 2'b00 && n < 10);
      tests++;
      if (m_ready !== (2'b01 << (k % 2)) || grant !== 1'(k % 2)) begin
        fails++;
        $display("FAIL rr_grant_%0d got r=%b g=%0d want r=%b g=%0d",
                 k, m_ready, grant, 2'b01 << (k % 2), k % 2);
      end
      if (k > 0) begin
        tests++;
        if (cyc - last != 3) begin
          fails++;
          $display("FAIL rr_period_%0d got %0d want 3", k, cyc - last);
        end
      end
      last = cyc;
    end
    tests++;
    if (m_rdata !== 32'ha5a5_0001) begin
      fails++;
      $display("FAIL rr_rdata got %h want a5a50001", m_rdata);
    end
    tick();
    m_valid = 2'b00;
    auto_ack = 1'b0;
    tick();
  endtask

  task automatic test_write();
    m_addr[63:32]  = 32'h8000_0004;
    m_wdata[63:32] = 32'hcafe_f00d;
    m_wstrb[7:4]   = 4'b0011;
    m_addr[31:0]   = 32'hdead_beef;
    m_valid = 2'b10;
    tick();
    #1;
    tests++;
    if (s_valid !== 1'b1 || s_addr !== 32'h8000_0004 ||
        s_wdata !== 32'hcafe_f00d || s_wstrb !== 4'b0011) begin
      fails++;
      $display("FAIL wr_bus got v=%b a=%h d=%h s=%b want 1 80000004 cafef00d 0011",
               s_valid, s_addr, s_wdata, s_wstrb);
    end
    tests++;
    if (grant !== 1'b1) begin
      fails++;
      $display("FAIL wr_grant got %0d want 1", grant);
    end
    tick();
    s_ready_man = 1'b1;
    #1;
    tests++;
    if (m_ready !== 2'b10) begin
      fails++;
      $display("FAIL wr_ready got %b want 10", m_ready);
    end
    tick();
    s_ready_man = 1'b0;
    m_valid = 2'b00;
    m_wstrb = '0;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    m_valid = 2'b01;
    for (int b = 1; b < 16; b++) begin
      tick();
      #1;
      if (m_ready !== 2'b00 || to_err !== 1'b0) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL to_early got %0d early cycles want 0", early);
    end
    tick();
    #1;
    tests++;
    if (m_ready !== 2'b01 || to_err !== 1'b1 || m_rdata !== 32'hffff_ffff) begin
      fails++;
      $display("FAIL to_expire got r=%b e=%b d=%h want r=01 e=1 d=ffffffff",
               m_ready, to_err, m_rdata);
    end
    tick();
    s_ready_man = 1'b1;
    m_valid = 2'b00;
    #1;
    tests++;
    if (m_ready !== 2'b00 || to_err !== 1'b0) begin
      fails++;
      $display("FAIL to_late_gap got r=%b e=%b want r=00 e=0", m_ready, to_err);
    end
    tick();
    #1;
    tests++;
    if (m_ready !== 2'b00) begin
      fails++;
      $display("FAIL to_late_idle got %b want 00", m_ready);
    end
    s_ready_man = 1'b0;
    tick();
  endtask

  task automatic test_timeout_race();
    m_valid = 2'b01;
    for (int b = 1; b < 16; b++) tick();
    tick();
    s_ready_man = 1'b1;
    s_rdata = 32'h0bad_f00d;
    #1;
    tests++;
    if (m_ready !== 2'b01 || to_err !== 1'b0 || m_rdata !== 32'h0bad_f00d) begin
      fails++;
      $display("FAIL race got r=%b e=%b d=%h want r=01 e=0 d=0badf00d",
               m_ready, to_err, m_rdata);
    end
    tick();
    s_ready_man = 1'b0;
    m_valid = 2'b00;
    #1;
    tests++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL race_gap got %b want 0", s_valid);
    end
    tick();
  endtask

  task automatic test_violation();
    m_valid = 2'b01;
    tick();
    m_valid = 2'b00;
    s_ready_man = 1'b1;
    #1;
    tests++;
    if (m_ready !== 2'b00 || to_err !== 1'b0) begin
      fails++;
      $display("FAIL viol_ready got r=%b e=%b want r=00 e=0", m_ready, to_err);
    end
    tick();
    #1;
    tests++;
    if (s_valid !== 1'b0 || grant !== 1'b0) begin
      fails++;
      $display("FAIL viol_idle got v=%b g=%0d want v=0 g=0", s_valid, grant);
    end
    s_ready_man = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    m_valid = 2'b01;
    tick();
    #1;
    tests++;
    if (s_valid !== 1'b1 || grant !== 1'b0) begin
      fails++;
      $display("FAIL rstm_busy got v=%b g=%0d want v=1 g=0", s_valid, grant);
    end
    rst = 1'b1;
    tick();
    #1;
    tests++;
    if (s_valid !== 1'b0 || grant !== 1'b1 || m_ready !== 2'b00) begin
      fails++;
      $display("FAIL rstm_reset got v=%b g=%0d r=%b want v=0 g=1 r=00",
               s_valid, grant, m_ready);
    end
    rst = 1'b0;
    m_valid = 2'b11;
    tick();
    s_ready_man = 1'b1;
    #1;
    tests++;
    if (grant !== 1'b0 || s_valid !== 1'b1 || m_ready !== 2'b01) begin
      fails++;
      $display("FAIL rstm_first got g=%0d v=%b r=%b want g=0 v=1 r=01",
               grant, s_valid, m_ready);
    end
    tick();
    s_ready_man = 1'b0;
    m_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_timeout_race();
    test_violation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
